// File: rtl/uart_rx_axis_fifo.sv
// UART receive buffer: absorbs the receiver's unthrottled word stream
// and re-presents it as an AXI-stream master with overflow tracking.
module uart_rx_axis_fifo #(
  parameter int DEPTH           = 16,
  parameter int DATA_WIDTH      = 8,
  parameter bit DROP_PARITY_ERR = 1'b0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tuser,
  input  logic                    s_tvalid,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  output logic [15:0]             ovf_count,
  input  logic                    clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY,
    HAS_DATA,
    FULL
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_d, rd_ptr_d;
  logic [AW:0] fill_d;
  logic [DATA_WIDTH:0] head_d;
  logic wr_req, is_full, rd, wr, loss;

  assign wr_req  = s_tvalid & ~(DROP_PARITY_ERR & s_tuser);
  assign is_full = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd   = m_tvalid & m_tready;
  assign wr   = wr_req & (~is_full | rd);
  assign loss = wr_req & is_full & ~rd;

  assign rd_ptr_d = rd_ptr + {{AW{1'b0}}, rd};
  assign wr_ptr_d = wr_ptr + {{AW{1'b0}}, wr};
  assign m_tvalid = (state_q != EMPTY);

  // Next fill level and the word that will sit at the head next cycle;
  // a word written into an otherwise-empty FIFO bypasses the array.
  always_comb begin
    fill_d = fill_level;
    if (wr && !rd)
      fill_d = fill_level + ONE;
    else if (rd && !wr)
      fill_d = fill_level - ONE;
    head_d = mem[rd_ptr_d[AW-1:0]];
    if (rd_ptr_d == wr_ptr)
      head_d = {s_tuser, s_tdata};
  end

  // Occupancy state follows the fill changes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (wr)
          state_d = HAS_DATA;
      end
      HAS_DATA: begin
        if (fill_d == '0)
          state_d = EMPTY;
        else if (fill_d == FULL_LVL)
          state_d = FULL;
      end
      FULL: begin
        if (rd && !wr)
          state_d = HAS_DATA;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pointers, fill level and state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      state_q    <= EMPTY;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      fill_level <= fill_d;
      state_q    <= state_d;
    end
  end

  // Registered output stage, reloaded whenever a head word exists.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_tdata <= '0;
      m_tuser <= 1'b0;
    end else if (fill_d != '0) begin
      {m_tuser, m_tdata} <= head_d;
    end
  end

  // Storage array; contents are don't-care until a pointer covers them.
  always_ff @(posedge aclk) begin
    if (wr)
      mem[wr_ptr[AW-1:0]] <= {s_tuser, s_tdata};
  end

  // Sticky overflow flag and saturating loss counter; clear wins.
  always_ff @(posedge aclk) begin
    if (areset || clear_ovf) begin
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else if (loss) begin
      overflow <= 1'b1;
      if (ovf_count != 16'hFFFF)
        ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench for uart_rx_axis_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_uart_rx_axis_fifo;

  localparam int DEPTH = 16;
  localparam int MSZ = 4096;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic [7:0] s_tdata = '0;
  logic s_tuser = 1'b0;
  logic s_tvalid = 1'b0;
  logic m_tready = 1'b0;
  logic clear_ovf = 1'b0;

  logic [7:0]  md [2];
  logic        mu [2];
  logic        mv [2];
  logic [4:0]  fl [2];
  logic        ov [2];
  logic [15:0] oc [2];

  int errors = 0;
  int checks = 0;

  logic [8:0] mb [2][MSZ];
  int mh [2];
  int mt [2];
  bit mo [2];
  int mc [2];

  always #5 aclk = ~aclk;

  uart_rx_axis_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(8), .DROP_PARITY_ERR(1'b0)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .m_tdata(md[0]), .m_tuser(mu[0]), .m_tvalid(mv[0]),
    .m_tready(m_tready), .fill_level(fl[0]),
    .overflow(ov[0]), .ovf_count(oc[0]), .clear_ovf(clear_ovf)
  );

  uart_rx_axis_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(8), .DROP_PARITY_ERR(1'b1)
  ) dut_d (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .m_tdata(md[1]), .m_tuser(mu[1]), .m_tvalid(mv[1]),
    .m_tready(m_tready), .fill_level(fl[1]),
    .overflow(ov[1]), .ovf_count(oc[1]), .clear_ovf(clear_ovf)
  );

  task automatic model_upd(input int k, input bit drop);
    bit rdo, wq;
    int n;
    if (areset) begin
      mh[k] = 0; mt[k] = 0; mo[k] = 0; mc[k] = 0;
      return;
    end
    n = mt[k] - mh[k];
    rdo = (n > 0) && m_tready;
    wq = s_tvalid && !(drop && s_tuser);
    if (clear_ovf) begin
      mo[k] = 0; mc[k] = 0;
    end
    if (rdo) mh[k]++;
    if (wq) begin
      if (n < DEPTH || rdo) begin
        mb[k][mt[k] % MSZ] = {s_tuser, s_tdata};
        mt[k]++;
      end else if (!clear_ovf) begin
        mo[k] = 1;
        if (mc[k] < 65535) mc[k]++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input bit u, input bit r, input bit c);
    s_tvalid = v; s_tdata = d; s_tuser = u;
    m_tready = r; clear_ovf = c;
    @(posedge aclk);
    model_upd(0, 1'b0);
    model_upd(1, 1'b1);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    checks++; if (mv[0] !== 1'b0) begin errors++;
      $display("FAIL reset_tvalid: got %b want 0", mv[0]); end
    checks++; if (md[0] !== 8'h00) begin errors++;
      $display("FAIL reset_tdata: got %h want 00", md[0]); end
    checks++; if (mu[0] !== 1'b0) begin errors++;
      $display("FAIL reset_tuser: got %b want 0", mu[0]); end
    checks++; if (fl[0] !== 5'd0) begin errors++;
      $display("FAIL reset_fill: got %0d want 0", fl[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++;
      $display("FAIL reset_ovf: got %b want 0", ov[0]); end
    checks++; if (oc[0] !== 16'd0) begin errors++;
      $display("FAIL reset_ovfcnt: got %0d want 0", oc[0]); end
    checks++; if (mv[1] !== 1'b0) begin errors++;
      $display("FAIL reset_tvalid_d: got %b want 0", mv[1]); end
    areset = 1'b0;
  endtask

  task automatic test_single;
    step(1, 8'hA5, 0, 1, 0);
    checks++;
    if (mv[0] !== 1'b1 || md[0] !== 8'hA5 || mu[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h u=%b want v=1 d=a5 u=0",
               mv[0], md[0], mu[0]);
    end
    step(0, 8'h00, 0, 1, 0);
    checks++; if (fl[0] !== 5'd0 || mv[0] !== 1'b0) begin errors++;
      $display("FAIL single_drain: got fill=%0d v=%b want 0 0",
               fl[0], mv[0]); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    checks++; if (fl[0] !== 5'd16 || ov[0] !== 1'b0) begin errors++;
      $display("FAIL ovf_fill16: got fill=%0d ovf=%b want 16 0",
               fl[0], ov[0]); end
    step(1, 8'h10, 0, 0, 0);
    checks++;
    if (fl[0] !== 5'd16 || ov[0] !== 1'b1 || oc[0] !== 16'd1) begin
      errors++;
      $display("FAIL ovf_loss: got fill=%0d ovf=%b cnt=%0d want 16 1 1",
               fl[0], ov[0], oc[0]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mv[0] !== 1'b1 || md[0] !== 8'(i)) begin errors++;
        $display("FAIL ovf_order[%0d]: got v=%b d=%h want v=1 d=%h",
                 i, mv[0], md[0], 8'(i)); end
      step(0, 8'h00, 0, 1, 0);
    end
    checks++;
    if (mv[0] !== 1'b0 || fl[0] !== 5'd0 || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: got v=%b fill=%0d ovf=%b want 0 0 1",
               mv[0], fl[0], ov[0]);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++; if (ov[0] !== 1'b0 || oc[0] !== 16'd0) begin errors++;
      $display("FAIL ovf_clear: got ovf=%b cnt=%0d want 0 0",
               ov[0], oc[0]); end
  endtask

  task automatic test_full_rw;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) step(1, 8'(32 + i), 0, 0, 0);
    step(1, 8'h55, 0, 1, 0);
    checks++; if (fl[0] !== 5'd16 || ov[0] !== 1'b0) begin errors++;
      $display("FAIL fullrw_fill: got fill=%0d ovf=%b want 16 0",
               fl[0], ov[0]); end
    step(1, 8'hEE, 0, 0, 0);
    checks++; if (ov[0] !== 1'b1 || oc[0] !== 16'd1) begin errors++;
      $display("FAIL fullrw_loss: got ovf=%b cnt=%0d want 1 1",
               ov[0], oc[0]); end
    step(1, 8'hEF, 0, 0, 1);
    checks++;
    if (ov[0] !== 1'b0 || oc[0] !== 16'd0 || fl[0] !== 5'd16) begin
      errors++;
      $display("FAIL clear_wins: got ovf=%b cnt=%0d fill=%0d want 0 0 16",
               ov[0], oc[0], fl[0]);
    end
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 8'(33 + i) : 8'h55;
      checks++; if (mv[0] !== 1'b1 || md[0] !== e) begin errors++;
        $display("FAIL fullrw_order[%0d]: got v=%b d=%h want v=1 d=%h",
                 i, mv[0], md[0], e); end
      step(0, 8'h00, 0, 1, 0);
    end
    checks++; if (mv[0] !== 1'b0) begin errors++;
      $display("FAIL fullrw_empty: got v=%b want 0", mv[0]); end
  endtask

  task automatic test_parity;
    logic [8:0] e0 [3];
    logic [8:0] e1 [2];
    e0[0] = 9'h011; e0[1] = 9'h122; e0[2] = 9'h033;
    e1[0] = 9'h011; e1[1] = 9'h033;
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 1, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    checks++; if (fl[0] !== 5'd3 || fl[1] !== 5'd2) begin errors++;
      $display("FAIL parity_fill: got keep=%0d drop=%0d want 3 2",
               fl[0], fl[1]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mv[0] !== 1'b1 || {mu[0], md[0]} !== e0[i]) begin errors++;
        $display("FAIL parity_keep[%0d]: got v=%b %h want v=1 %h",
                 i, mv[0], {mu[0], md[0]}, e0[i]); end
      checks++;
      if (i < 2) begin
        if (mv[1] !== 1'b1 || {mu[1], md[1]} !== e1[i]) begin errors++;
          $display("FAIL parity_drop[%0d]: got v=%b %h want v=1 %h",
                   i, mv[1], {mu[1], md[1]}, e1[i]); end
      end else if (mv[1] !== 1'b0) begin errors++;
        $display("FAIL parity_drop_end: got v=%b want 0", mv[1]);
      end
      step(0, 8'h00, 0, 1, 0);
    end
    checks++; if (oc[1] !== 16'd0 || ov[1] !== 1'b0) begin errors++;
      $display("FAIL parity_noovf: got cnt=%0d ovf=%b want 0 0",
               oc[1], ov[1]); end
  endtask

  task automatic test_stall;
    step(1, 8'h77, 0, 0, 0);
    step(1, 8'h78, 0, 0, 0);
    checks++; if (mv[0] !== 1'b1 || md[0] !== 8'h77) begin errors++;
      $display("FAIL stall_c1: got v=%b d=%h want 1 77", mv[0], md[0]); end
    step(0, 8'h00, 0, 0, 0);
    checks++; if (md[0] !== 8'h77) begin errors++;
      $display("FAIL stall_c2: got %h want 77", md[0]); end
    step(0, 8'h00, 0, 1, 0);
    checks++; if (mv[0] !== 1'b1 || md[0] !== 8'h78) begin errors++;
      $display("FAIL stall_adv: got v=%b d=%h want 1 78", mv[0], md[0]); end
    step(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 16; i++) step(1, 8'(64 + i), 0, 0, 0);
    step(1, 8'h50, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 0, 1, 0);
    checks++; if (fl[0] !== 5'd5 || ov[0] !== 1'b1) begin errors++;
      $display("FAIL rstmid_pre: got fill=%0d ovf=%b want 5 1",
               fl[0], ov[0]); end
    areset = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    areset = 1'b0;
    checks++;
    if (mv[0] !== 1'b0 || fl[0] !== 5'd0 || ov[0] !== 1'b0
        || oc[0] !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_post: got v=%b fill=%0d ovf=%b cnt=%0d want 0",
               mv[0], fl[0], ov[0], oc[0]);
    end
    step(1, 8'h99, 0, 0, 0);
    checks++;
    if (mv[0] !== 1'b1 || md[0] !== 8'h99 || fl[0] !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_write: got v=%b d=%h fill=%0d want 1 99 1",
               mv[0], md[0], fl[0]);
    end
    step(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_random;
    int n;
    int rp;
    logic [8:0] hd;
    for (int c = 0; c < 1500; c++) begin
      rp = ((c / 100) % 2 == 0) ? 20 : 85;
      areset = ($urandom_range(0, 399) == 0);
      step(bit'($urandom_range(0, 99) < 60), 8'($urandom),
           bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 99) < rp),
           bit'($urandom_range(0, 59) == 0));
      areset = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n = mt[k] - mh[k];
        hd = mb[k][mh[k] % MSZ];
        checks++;
        if (mv[k] !== (n > 0) || fl[k] !== 5'(n) || ov[k] !== mo[k]
            || oc[k] !== 16'(mc[k])
            || ((n > 0) && {mu[k], md[k]} !== hd)) begin
          errors++;
          $display("FAIL random[%0d] k=%0d: got v=%b h=%h f=%0d o=%b c=%0d want n=%0d h=%h o=%b c=%0d",
                   c, k, mv[k], {mu[k], md[k]}, fl[k], ov[k], oc[k],
                   n, hd, mo[k], mc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_rw();
    test_parity();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
